// File: rtl/fc2_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fc2_sched
//  Description : Sequencer for a bank of NUM_COL fc2_column accumulators.
//                Drives the shared in_count phase, feature/weight/bias read
//                addresses, captures each group's rounded column sums and
//                repeats the pass NUM_GROUPS times.
//                Optional running argmax over all outputs: FC2_ARGMAX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc2_sched #(
   parameter int NUM_COL    = 4,
   parameter int NUM_GROUPS = 3,
   parameter int SUM_W      = 25,
   parameter int GRP_W      = 2
`ifdef FC2_ARGMAX_EN
   ,
   parameter int IDX_W      = ((NUM_COL * NUM_GROUPS) > 1) ? $clog2(NUM_COL * NUM_GROUPS) : 1
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [8:0]                 in_count,
   output logic                       feat_rd,
   output logic [7:0]                 feat_addr,
   output logic [GRP_W+7:0]           w_addr,
   output logic [GRP_W-1:0]           b_addr,
   input  logic [NUM_COL*SUM_W-1:0]   col_sum,
   output logic                       res_valid,
   output logic [GRP_W-1:0]           res_group,
   output logic [NUM_COL*SUM_W-1:0]   res_data
`ifdef FC2_ARGMAX_EN
   ,
   output logic [IDX_W-1:0]           max_idx,
   output logic signed [SUM_W-1:0]    max_val
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [8:0]       c_CNT_LAST = 9'd260;
   localparam logic [8:0]       c_CNT_FEAT = 9'd256;
   localparam logic [8:0]       c_IN_IDLE  = 9'd511;
   localparam logic [GRP_W-1:0] c_LAST_GRP = GRP_W'(NUM_GROUPS - 1);

   state_t            r_state, w_state_nxt;
   logic [8:0]        r_cnt, w_cnt_nxt;
   logic [GRP_W-1:0]  r_group, w_group_nxt;
   logic              w_accept;
   logic              w_capture;

   assign w_accept  = (r_state == S_IDLE) && start;
   assign w_capture = (r_state == S_RUN) && (r_cnt == c_CNT_LAST);

   // State, phase counter and group index registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 9'd0;
         r_group <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_group <= w_group_nxt;
      end
   end

   // Next-state: free-running phase count, group advance after phase 260
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_group_nxt = r_group;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = 9'd0;
               w_group_nxt = '0;
            end
         end
         S_RUN: begin
            if (r_cnt == c_CNT_LAST) begin
               w_cnt_nxt = 9'd0;
               if (r_group != c_LAST_GRP) begin
                  w_group_nxt = r_group + 1'b1;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 9'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Registered outputs derived from the next state so they align with in_count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         in_count  <= c_IN_IDLE;
         feat_rd   <= 1'b0;
         feat_addr <= 8'd0;
         w_addr    <= '0;
         b_addr    <= '0;
      end else begin
         busy     <= (w_state_nxt != S_IDLE);
         done     <= (w_state_nxt == S_DONE);
         in_count <= (w_state_nxt == S_RUN) ? w_cnt_nxt : c_IN_IDLE;
         feat_rd  <= (w_state_nxt == S_RUN) && (w_cnt_nxt < c_CNT_FEAT);
         if ((w_state_nxt == S_RUN) && (w_cnt_nxt < c_CNT_FEAT)) begin
            feat_addr <= w_cnt_nxt[7:0];
            w_addr    <= {w_group_nxt, w_cnt_nxt[7:0]};
         end
         if (w_state_nxt == S_RUN) begin
            b_addr <= w_group_nxt;
         end
      end
   end

   // Capture rounded column sums at phase 260, flag them one cycle later
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_group <= '0;
         res_data  <= '0;
      end else begin
         res_valid <= w_capture;
         if (w_capture) begin
            res_data  <= col_sum;
            res_group <= r_group;
         end
      end
   end

`ifdef FC2_ARGMAX_EN
   logic                     r_max_have, w_am_have;
   logic [IDX_W-1:0]         r_max_idx, w_am_idx;
   logic signed [SUM_W-1:0]  r_max_val, w_am_val;

   // Scan this group's slices in column order; strict compare keeps lowest index
   always_comb begin
      w_am_have = r_max_have;
      w_am_idx  = r_max_idx;
      w_am_val  = r_max_val;
      for (int c = 0; c < NUM_COL; c++) begin
         if (!w_am_have || ($signed(col_sum[c*SUM_W +: SUM_W]) > w_am_val)) begin
            w_am_have = 1'b1;
            w_am_val  = $signed(col_sum[c*SUM_W +: SUM_W]);
            w_am_idx  = IDX_W'(int'(r_group) * NUM_COL + c);
         end
      end
   end

   // Running maximum, cleared when a new pass is accepted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_max_have <= 1'b0;
         r_max_idx  <= '0;
         r_max_val  <= '0;
      end else if (w_accept) begin
         r_max_have <= 1'b0;
      end else if (w_capture) begin
         r_max_have <= w_am_have;
         r_max_idx  <= w_am_idx;
         r_max_val  <= w_am_val;
      end
   end

   assign max_idx = r_max_idx;
   assign max_val = r_max_val;
`else
   logic w_unused_accept;
   assign w_unused_accept = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc2_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc2_sched
//  Description : Self-checking bench for fc2_sched. Expected outputs come from
//                a cycle-position model of the pass (position since start
//                accepted, split into group / phase with division).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc2_sched;
   localparam int NUM_COL    = 4;
   localparam int NUM_GROUPS = 3;
   localparam int SUM_W      = 25;
   localparam int GRP_W      = 2;
   localparam int PHASES     = 261;
   localparam int RUNLEN     = PHASES * NUM_GROUPS;
`ifdef FC2_ARGMAX_EN
   localparam int IDX_W      = $clog2(NUM_COL * NUM_GROUPS);
`endif

   logic                      clk;
   logic                      rst_n;
   logic                      start;
   logic                      busy;
   logic                      done;
   logic [8:0]                in_count;
   logic                      feat_rd;
   logic [7:0]                feat_addr;
   logic [GRP_W+7:0]          w_addr;
   logic [GRP_W-1:0]          b_addr;
   logic [NUM_COL*SUM_W-1:0]  col_sum;
   logic                      res_valid;
   logic [GRP_W-1:0]          res_group;
   logic [NUM_COL*SUM_W-1:0]  res_data;
`ifdef FC2_ARGMAX_EN
   logic [IDX_W-1:0]          max_idx;
   logic signed [SUM_W-1:0]   max_val;
`endif

   fc2_sched #(
      .NUM_COL(NUM_COL), .NUM_GROUPS(NUM_GROUPS), .SUM_W(SUM_W), .GRP_W(GRP_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .in_count(in_count), .feat_rd(feat_rd), .feat_addr(feat_addr),
      .w_addr(w_addr), .b_addr(b_addr), .col_sum(col_sum),
      .res_valid(res_valid), .res_group(res_group), .res_data(res_data)
`ifdef FC2_ARGMAX_EN
      , .max_idx(max_idx), .max_val(max_val)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int n_rv_obs = 0;
   int n_rv_exp = 0;

   // model state: pos = -1 idle, else cycles since start accepted (1..RUNLEN+1)
   int                        pos = -1;
   logic [7:0]                e_faddr = '0;
   logic [GRP_W+7:0]          e_waddr = '0;
   logic [GRP_W-1:0]          e_baddr = '0;
   logic                      e_rv = 1'b0;
   logic [GRP_W-1:0]          e_rgrp = '0;
   logic [NUM_COL*SUM_W-1:0]  e_rdata = '0;
   int                        dir_mode = 0;
   logic signed [SUM_W-1:0]   tab [3][NUM_COL];
   bit                        am_have = 0;
   bit                        am_ok = 0;
   int                        am_idx = 0;
   logic signed [SUM_W-1:0]   am_val = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic       e_busy, e_done, e_frd;
      logic [8:0] e_in;
      int         idx, g, k;
      e_busy = (pos >= 1);
      e_done = (pos == RUNLEN + 1);
      e_in   = 9'd511;
      e_frd  = 1'b0;
      if (pos >= 1 && pos <= RUNLEN) begin
         idx = pos - 1;
         g   = idx / PHASES;
         k   = idx % PHASES;
         e_in    = 9'(k);
         e_baddr = GRP_W'(g);
         if (k < 256) begin
            e_frd   = 1'b1;
            e_faddr = 8'(k);
            e_waddr = {GRP_W'(g), 8'(k)};
         end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("in_count", in_count, e_in);
      chk("feat_rd", feat_rd, e_frd);
      chk("feat_addr", feat_addr, e_faddr);
      chk("w_addr", w_addr, e_waddr);
      chk("b_addr", b_addr, e_baddr);
      chk("res_valid", res_valid, e_rv);
      chk("res_group", res_group, e_rgrp);
      chk("res_data", res_data, e_rdata);
      if (res_valid === 1'b1) n_rv_obs++;
`ifdef FC2_ARGMAX_EN
      if (e_done) am_ok = 1;
      if (am_ok) begin
         chk("max_idx", max_idx, IDX_W'(am_idx));
         chk("max_val", max_val, am_val);
      end
`endif
   endtask

   task automatic step();
      logic signed [SUM_W-1:0] v;
      if (!rst_n) begin
         pos = -1; e_faddr = '0; e_waddr = '0; e_baddr = '0;
         e_rv = 1'b0; e_rgrp = '0; e_rdata = '0; am_ok = 0; am_have = 0;
      end else begin
         e_rv = 1'b0;
         if (pos >= 1 && pos <= RUNLEN && ((pos - 1) % PHASES) == 260) begin
            e_rv    = 1'b1;
            e_rgrp  = GRP_W'((pos - 1) / PHASES);
            e_rdata = col_sum;
            n_rv_exp++;
            for (int c = 0; c < NUM_COL; c++) begin
               v = col_sum[c*SUM_W +: SUM_W];
               if (!am_have || v > am_val) begin
                  am_have = 1; am_val = v; am_idx = ((pos - 1) / PHASES) * NUM_COL + c;
               end
            end
         end
         if (pos == -1) begin
            if (start) begin
               pos = 1; am_have = 0; am_ok = 0;
            end
         end else if (pos == RUNLEN + 1) begin
            pos = -1;
         end else begin
            pos++;
         end
      end
   endtask

   task automatic cyc(input logic st, input logic rn);
      int g, k;
      start = st;
      rst_n = rn;
      for (int c = 0; c < NUM_COL; c++) col_sum[c*SUM_W +: SUM_W] = SUM_W'($urandom);
      if (dir_mode != 0 && pos >= 1 && pos <= RUNLEN) begin
         g = (pos - 1) / PHASES;
         k = (pos - 1) % PHASES;
         if (k == 260 && (dir_mode == 2 || g == 1)) begin
            for (int c = 0; c < NUM_COL; c++) col_sum[c*SUM_W +: SUM_W] = tab[g][c];
         end
      end
      @(negedge clk);
      check_all();
      step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rv0;
      bit reached;
      rst_n = 1'b0; start = 1'b0; col_sum = '0;
      @(posedge clk);
      #1;
      // reset held, then idle
      cyc(0, 0); cyc(0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1);

      // single start pulse; group 1 returns 100,-5,7,0
      tab[1][0] = 25'sd100; tab[1][1] = -25'sd5; tab[1][2] = 25'sd7; tab[1][3] = 25'sd0;
      dir_mode = 1;
      rv0 = n_rv_obs;
      cyc(1, 1);
      for (int i = 0; i < RUNLEN + 5; i++) cyc(0, 1);
      chk("rv_count_pass1", 128'(n_rv_obs - rv0), 128'd3);
      dir_mode = 0;

      // start held high through a pass and into the next one
      for (int i = 0; i < RUNLEN + 10; i++) cyc(1, 1);
      // random start pulses, then drain
      for (int i = 0; i < 900; i++) cyc(1'($urandom_range(0, 1)), 1);
      for (int i = 0; i < RUNLEN + 5; i++) cyc(0, 1);

      // reset during group 1, phase 100
      cyc(1, 1);
      reached = 0;
      for (int i = 0; i < 2000 && !reached; i++) begin
         if (pos == PHASES + 101) reached = 1;
         else cyc(0, 1);
      end
      chk("reach_mid_pass", 128'(reached), 128'd1);
      cyc(0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1);

      // fresh pass with argmax tie pattern
      tab[0][0] = 25'sd3;  tab[0][1] = 25'sd9;  tab[0][2] = 25'sd9;  tab[0][3] = -25'sd1;
      tab[1][0] = 25'sd9;  tab[1][1] = 25'sd2;  tab[1][2] = 25'sd0;  tab[1][3] = 25'sd0;
      tab[2][0] = -25'sd4; tab[2][1] = -25'sd4; tab[2][2] = -25'sd4; tab[2][3] = -25'sd4;
      dir_mode = 2;
      cyc(1, 1);
      for (int i = 0; i < RUNLEN + 5; i++) cyc(0, 1);
      dir_mode = 0;
`ifdef FC2_ARGMAX_EN
      chk("argmax_idx_final", max_idx, IDX_W'(1));
      chk("argmax_val_final", max_val, 25'sd9);
`endif
      chk("rv_total", 128'(n_rv_obs), 128'(n_rv_exp));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fc2_sched.md
Name: fc2_sched

Overview:
Sequencer for a bank of NUM_COL parallel fc2_column accumulators. It generates the shared in_count phase, and the feature, weight and bias read addresses. It captures each column's rounded result, then repeats the pass NUM_GROUPS times so NUM_COL*NUM_GROUPS output neurons share one column bank. It sits between the FC1 feature buffer / FC2 weight ROM and the result buffer.

Parameters:
NUM_COL, 4, number of physical columns driven in parallel
NUM_GROUPS, 3, output groups time-multiplexed onto the column bank (>=1)
SUM_W, 25, signed width of each column sum
GRP_W, 2, width of group index; must satisfy 2**GRP_W >= NUM_GROUPS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  request a full layer pass; sampled only in IDLE
busy  out  1  high from cycle after start accepted until done cycle inclusive
done  out  1  one-cycle pulse at end of pass
in_count  out  9  phase counter broadcast to all columns
feat_rd  out  1  feature buffer read enable
feat_addr  out  8  feature index 0..255
w_addr  out  GRP_W+8  weight ROM address = {group, feat index}
b_addr  out  GRP_W  bias ROM address = current group
col_sum  in  NUM_COL*SUM_W  packed column sums, col 0 in LSBs, signed per slice
res_valid  out  1  one-cycle pulse; res_data/res_group valid
res_group  out  GRP_W  group index of res_data
res_data  out  NUM_COL*SUM_W  captured column sums

Behaviour:
- States: IDLE, RUN, DONE. Internal cnt 0..260 and group 0..NUM_GROUPS-1.
- Reset values: busy=0, done=0, feat_rd=0, feat_addr=0, w_addr=0, b_addr=0, res_valid=0, res_group=0, res_data=0, in_count=9'd511, state=IDLE, cnt=0, group=0.
- IDLE: in_count=511, which holds columns cleared. When start=1, go to RUN with cnt=0, group=0. busy rises the next cycle.
- RUN: in_count=cnt, registered output. cnt increments every cycle; there is no stall.
  - cnt 0..255: feat_rd=1, feat_addr=cnt[7:0], w_addr={group,cnt[7:0]}.
  - cnt >=256: feat_rd=0, addresses hold last value.
  - b_addr=group throughout RUN.
  - Column phases follow from in_count: 257 adds bias, 258 rounds, 259 holds, 260 clears.
- Capture: in the cycle with in_count==260, col_sum is the rounded result. Register col_sum into res_data and group into res_group. Pulse res_valid in the following cycle.
- After cnt==260:
  - If group<NUM_GROUPS-1: group++, cnt=0, stay in RUN. Back-to-back groups have no idle gap.
  - Otherwise go to DONE.
- DONE: lasts one cycle. done=1, busy=1, in_count=511, and the last res_valid pulse coincides. Then return to IDLE, busy=0.
- Pass length: start accepted at cycle T. First in_count=0 at T+1. done at T+1+261*NUM_GROUPS.
- start while busy is ignored, with no queueing. start in the DONE cycle is also ignored.
- rst_n low mid-pass: next edge forces all reset values. No res_valid or done is emitted for the aborted pass.
- res_data holds its value until the next capture.

Optional Feature:
FC2_ARGMAX_EN
- Defined: adds outputs max_idx (width clog2(NUM_COL*NUM_GROUPS)) and max_val (SUM_W, signed).
  - On each capture, compare every slice signed, col 0 first, then later groups.
  - Strict greater-than updates the running max, so ties keep the lowest index. Index = group*NUM_COL+col.
  - The running max is reset at pass start.
  - max_idx/max_val are final and stable from the done cycle until the next start is accepted.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle 10 cycles -> in_count=511, busy=0, feat_rd=0, all outputs at reset values.
- start pulse at T, NUM_GROUPS=3 -> in_count 0..260 three times, w_addr 0x000..0x0FF then 0x100..0x1FF then 0x200..0x2FF, b_addr 0/1/2, done exactly at T+784, busy high T+1..T+784.
- Model columns returning slice values 100,-5,7,0 at in_count 260 of group 1 -> res_valid one cycle later with res_group=1 and matching res_data; exactly 3 res_valid pulses total.
- start held high continuously through a pass -> a second pass begins only after returning to IDLE (first in_count=0 two cycles after done); start pulses mid-pass produce no extra passes.
- rst_n low for one cycle at group 1, cnt 100 -> next cycle all reset values, no done or res_valid; a fresh start runs a full 3-group pass.
- FC2_ARGMAX_EN: group sums {3,9,9,-1},{9,2,0,0},{-4,-4,-4,-4} -> max_idx=1, max_val=9 at done (tie with idx 2 and idx 4 keeps lowest index).
